// File: rtl/hazard_ctl_if.sv
// ID/EX hazard-control bundle between the core pipeline (master) and hazard_ctl (slave).
interface hazard_ctl_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] id_rd;
  logic              id_reg_wen;
  logic [1:0]        id_wb_sel;
  logic              ex_pc_sel;
  logic              stall_if;
  logic              stall_id;
  logic              flush_id;
  logic              flush_ex;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_reg_wen,
           id_wb_sel, ex_pc_sel,
    input  stall_if, stall_id, flush_id, flush_ex, fwd_a_sel, fwd_b_sel, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_reg_wen,
           id_wb_sel, ex_pc_sel,
    output stall_if, stall_id, flush_id, flush_ex, fwd_a_sel, fwd_b_sel, stall_cnt
  );
endinterface

// File: rtl/hazard_ctl.sv
// Hazard controller for the rv32 5-stage pipeline: stall/flush decisions and EX operand forwarding.
// HAZARD_FWD_EN defined: forwarding enabled, only load-use stalls; undefined: stall until producer is in WB.
module hazard_ctl #(
  parameter int unsigned REG_AW = 5,
  parameter logic [1:0]  WB_MEM = 2'b00,
  parameter int unsigned CNT_W  = 16
) (
  input logic       clk,
  input logic       rst_n,
  hazard_ctl_if.slave hz
);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              wen;
    logic              ld;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              u1;
    logic              u2;
  } slot_t;

  slot_t            ex_q, mem_q, wb_q, id_slot;
  logic [CNT_W-1:0] cnt_q;
  logic             hazard_c, stall_c;
  logic             unused_slot_bits;

  // x0 is hardwired zero, so a slot targeting it never produces a dependency
  function automatic logic writes(input slot_t s, input logic [REG_AW-1:0] r);
    return s.v & s.wen & (s.rd == r) & (r != '0);
  endfunction

  function automatic logic [1:0] fwd_pick(input slot_t ex, input slot_t mem, input slot_t wb,
                                          input logic used, input logic [REG_AW-1:0] r);
    logic [1:0] sel;
    sel = 2'b00;
    if (ex.v && used) begin
      if (writes(mem, r))     sel = 2'b01;
      else if (writes(wb, r)) sel = 2'b10;
    end
    return sel;
  endfunction

  // Decoded ID fields as they would enter the EX slot
  always_comb begin
    id_slot     = '0;
    id_slot.v   = 1'b1;
    id_slot.rd  = hz.id_rd;
    id_slot.wen = hz.id_reg_wen;
    id_slot.ld  = (hz.id_wb_sel == WB_MEM);
    id_slot.rs1 = hz.id_rs1;
    id_slot.rs2 = hz.id_rs2;
    id_slot.u1  = hz.id_rs1_used;
    id_slot.u2  = hz.id_rs2_used;
  end

  always_comb begin
    hazard_c = 1'b0;
`ifdef HAZARD_FWD_EN
    hazard_c = ex_q.ld & ((hz.id_rs1_used & writes(ex_q, hz.id_rs1)) |
                          (hz.id_rs2_used & writes(ex_q, hz.id_rs2)));
`else
    hazard_c = (hz.id_rs1_used & (writes(ex_q, hz.id_rs1) | writes(mem_q, hz.id_rs1))) |
               (hz.id_rs2_used & (writes(ex_q, hz.id_rs2) | writes(mem_q, hz.id_rs2)));
`endif
  end

  // A redirect squashes the wrong-path ID instruction, so it overrides any stall
  assign stall_c = rst_n & hz.id_valid & hazard_c & ~hz.ex_pc_sel;

  always_comb begin
    hz.stall_if  = 1'b0;
    hz.stall_id  = 1'b0;
    hz.flush_id  = 1'b0;
    hz.flush_ex  = 1'b0;
    hz.fwd_a_sel = 2'b00;
    hz.fwd_b_sel = 2'b00;
    if (rst_n) begin
      hz.stall_if = stall_c;
      hz.stall_id = stall_c;
      hz.flush_id = hz.ex_pc_sel;
      hz.flush_ex = hz.ex_pc_sel | stall_c;
`ifdef HAZARD_FWD_EN
      hz.fwd_a_sel = fwd_pick(ex_q, mem_q, wb_q, ex_q.u1, ex_q.rs1);
      hz.fwd_b_sel = fwd_pick(ex_q, mem_q, wb_q, ex_q.u2, ex_q.rs2);
`endif
    end
  end

  assign hz.stall_cnt = cnt_q;

  // Scoreboard shift and saturating stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= (hz.id_valid && !stall_c && !hz.ex_pc_sel) ? id_slot : '0;
      if (stall_c && (cnt_q != '1)) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign unused_slot_bits = ^{ex_q, mem_q, wb_q};

endmodule
